// File: rtl/sum_accumulator.sv
// Frame accumulator: sums FRAME_LEN 9-bit adder results {cout, sum} into an
// ACC_W-bit total, presents it with a valid/ready handshake and counts frames.
module sum_accumulator #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic [7:0]       fcnt_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [ACC_W-1:0] operand_s;
  logic [ACC_W:0]   sum_s;
  logic             last_s;
  logic             in_xfer_s;

  // Operand extension, carry-extended sum and frame-completion decode.
  always_comb begin
    operand_s      = '0;
    operand_s[8:0] = {in_cout, in_sum};
    sum_s          = {1'b0, acc_q} + {1'b0, operand_s};
    last_s         = (cnt_q == 8'(FRAME_LEN - 1));
    in_xfer_s      = in_valid && in_ready_q;
  end

  // Frame FSM; in_ready and out_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      ovf_q       <= 1'b0;
      fcnt_q      <= 8'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (in_xfer_s) begin
            acc_q <= sum_s[ACC_W-1:0];
            cnt_q <= cnt_q + 8'd1;
            ovf_q <= ovf_q | sum_s[ACC_W];
            if (last_s) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        HOLD: begin
          // Handshake cycle: in_ready is already low, so no input slips in.
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            fcnt_q      <= fcnt_q + 8'd1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= 8'd0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 4, giving the number of adder results per frame (legal range 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 16, giving the accumulator width in bits (legal range 9..32).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: the upstream 8-bit adder result is valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an input this cycle.
REQ-008 Port in_sum, input, 8 bits: adder sum bits s[7:0].
REQ-009 Port in_cout, input, 1 bit: adder carry-out.
REQ-010 Port out_valid, output, 1 bit: a frame result is presented.
REQ-011 Port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-012 Port out_acc, output, ACC_W bits: the frame total.
REQ-013 Port out_ovf, output, 1 bit: the frame total wrapped.
REQ-014 Port frame_cnt, output, 8 bits: count of completed frame handshakes.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; the operand is the 9-bit value {in_cout, in_sum}, zero-extended to ACC_W.
REQ-016 The FSM SHALL have states IDLE (no samples held), ACC (1..FRAME_LEN-1 samples held) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD; it SHALL be registered or state-decoded only, with no combinational path from out_ready.
REQ-018 On a transfer in IDLE or ACC: acc <= acc + operand mod 2^ACC_W; sample count increments; ovf_sticky is set if the addition carries out of bit ACC_W-1.
REQ-019 The FRAME_LEN-th transfer SHALL move the FSM to HOLD, with out_valid = 1 on the next cycle (1-cycle latency from the last transfer). If FRAME_LEN = 1, the FSM goes from IDLE directly to HOLD.
REQ-020 Other transfers SHALL move IDLE->ACC or keep ACC; cycles without a transfer SHALL leave all state unchanged (gaps allowed).
REQ-021 In HOLD, out_acc, out_ovf and out_valid SHALL stay stable until out_ready = 1.
REQ-022 When out_valid and out_ready are both 1: the FSM goes to HOLD->IDLE; acc, the sample count and ovf_sticky clear; frame_cnt increments, wrapping 255->0.
REQ-023 The block SHALL accept no input in the cycle of the output handshake; the first input of the next frame is accepted one cycle later, at the earliest.
REQ-024 out_acc SHALL equal acc at all times; out_ovf SHALL equal ovf_sticky; both are meaningful only while out_valid = 1.

Reset
REQ-025 When rst = 1, the block SHALL set: FSM = IDLE; acc = 0; sample count = 0; ovf_sticky = 0; frame_cnt = 0; out_valid = 0; in_ready = 1 on the first cycle after release.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-027 While rst = 1, in_valid SHALL be ignored.

Verification
REQ-028 Basic frame: FRAME_LEN=4, inputs in_sum = 0x10, 0x20, 0x30, 0x40 with cout=0, out_ready=1 -> out_valid=1 one cycle after the 4th transfer, out_acc=0x00A0, out_ovf=0, frame_cnt goes 0->1.
REQ-029 Carry inclusion: FRAME_LEN=4, four inputs of in_sum=0xFF with cout=1 -> out_acc=0x07FC, out_ovf=0.
REQ-030 Wrap: ACC_W=9, FRAME_LEN=2, inputs {1,0xFF} then {0,0x01} -> out_acc=0x000, out_ovf=1; the next frame {0,0x05},{0,0x05} -> out_acc=0x00A, out_ovf=0.
REQ-031 Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_acc stable, no sample accepted; on out_ready=1 the handshake completes, and the next input is accepted no earlier than the following cycle.
REQ-032 Reset mid-frame: 2 of 4 samples (0x11, 0x22) accepted, rst pulsed 1 cycle, then 0x01, 0x02, 0x03, 0x04 -> out_acc=0x000A, frame_cnt=1, and no result is emitted for the aborted frame.
REQ-033 Gaps and wrap: in_valid toggling randomly over 256 frames of FRAME_LEN=1 -> every out_acc matches the reference model, and frame_cnt reads 0 after the 256th handshake.
